// File: rtl/i2c_target.sv
// i2c_target: 7-bit addressed I2C target with filtered inputs, valid/ready byte ports and SCL stretching on reads
module i2c_target #(
    parameter int         SYSTEM_CLK_HZ = 100_000_000,
    parameter logic [6:0] ADDRESS       = 7'h42,
    parameter int         FILTER_LEN    = 3,
    localparam int        WIDTH         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_scl,
    input  logic             i_sda,
    output logic             o_scl_oe,
    output logic             o_sda_oe,
    output logic [WIDTH-1:0] o_rx_data,
    output logic             o_rx_valid,
    input  logic             i_rx_ready,
    input  logic [WIDTH-1:0] i_tx_data,
    input  logic             i_tx_valid,
    output logic             o_tx_ready,
    output logic             o_busy,
    output logic             o_nack_det
);
    localparam int CW = $clog2(FILTER_LEN + 1);

    if (SYSTEM_CLK_HZ < 20 * 400_000) begin : g_clk_check
        $error("SYSTEM_CLK_HZ too low to oversample fast-mode SCL");
    end

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_WR_DATA, S_WR_ACK,
        S_RD_LOAD, S_RD_DATA, S_RD_ACK, S_IGNORE
    } state_t;

    // bit 0 = SCL, bit 1 = SDA
    logic [1:0]       r_sync1, r_sync2, r_filt, r_prev;
    logic [CW-1:0]    r_fcnt [2];
    state_t           r_state;
    logic [WIDTH-1:0] r_shift, r_rx_data;
    logic [2:0]       r_bits;
    logic             r_phase, r_rw, r_rx_ok;
    logic             r_scl_oe, r_sda_oe, r_rx_valid, r_tx_ready, r_nack_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= '1;
            r_sync2  <= '1;
            r_filt   <= '1;
            r_prev   <= '1;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_sync1 <= {i_sda, i_scl};
            r_sync2 <= r_sync1;
            r_prev  <= r_filt;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_filt[k]) begin
                    r_fcnt[k] <= '0;
                end else if (r_fcnt[k] == CW'(FILTER_LEN - 1)) begin
                    r_filt[k] <= r_sync2[k];
                    r_fcnt[k] <= '0;
                end else begin
                    r_fcnt[k] <= r_fcnt[k] + 1'b1;
                end
            end
        end
    end

    logic             w_sda, w_rise, w_fall, w_start, w_stop;
    logic [WIDTH-1:0] w_byte;
    assign w_sda   = r_filt[1];
    assign w_rise  = r_filt[0] & ~r_prev[0];
    assign w_fall  = ~r_filt[0] & r_prev[0];
    assign w_start = r_filt[0] & r_prev[0] & r_prev[1] & ~r_filt[1];
    assign w_stop  = r_filt[0] & r_prev[0] & ~r_prev[1] & r_filt[1];
    assign w_byte  = {r_shift[WIDTH-2:0], w_sda};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_rx_data  <= '0;
            r_bits     <= '0;
            r_phase    <= 1'b0;
            r_rw       <= 1'b0;
            r_rx_ok    <= 1'b0;
            r_scl_oe   <= 1'b0;
            r_sda_oe   <= 1'b0;
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_nack_det <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_tx_ready <= 1'b0;
            r_nack_det <= 1'b0;
            if (w_start) begin
                r_state  <= S_ADDR;
                r_bits   <= '0;
                r_shift  <= '0;
                r_phase  <= 1'b0;
                r_sda_oe <= 1'b0;
                r_scl_oe <= 1'b0;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                r_scl_oe <= 1'b0;
            end else begin
                case (r_state)
                    S_ADDR: if (w_rise) begin
                        r_shift <= w_byte;
                        r_bits  <= r_bits + 1'b1;
                        if (r_bits == 3'd7) begin
                            r_rw    <= w_sda;
                            r_state <= (w_byte[7:1] == ADDRESS) ? S_ADDR_ACK : S_IGNORE;
                        end
                    end
                    // first fall starts the ACK, second fall ends it
                    S_ADDR_ACK: if (w_fall) begin
                        r_phase  <= ~r_phase;
                        r_sda_oe <= ~r_phase;
                        if (r_phase) r_state <= r_rw ? S_RD_LOAD : S_WR_DATA;
                    end
                    S_WR_DATA: if (w_rise) begin
                        r_shift <= w_byte;
                        r_bits  <= r_bits + 1'b1;
                        if (r_bits == 3'd7) begin
                            r_rx_data  <= w_byte;
                            r_rx_valid <= i_rx_ready;
                            r_rx_ok    <= i_rx_ready;
                            r_state    <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: if (w_fall) begin
                        r_sda_oe <= ~r_phase & r_rx_ok;
                        r_phase  <= ~r_phase & r_rx_ok;
                        if (r_phase || !r_rx_ok) r_state <= r_rx_ok ? S_WR_DATA : S_IGNORE;
                    end
                    S_RD_LOAD: if (i_tx_valid) begin
                        r_shift    <= {i_tx_data[WIDTH-2:0], 1'b0};
                        r_tx_ready <= 1'b1;
                        r_sda_oe   <= ~i_tx_data[WIDTH-1];
                        r_scl_oe   <= 1'b0;
                        r_state    <= S_RD_DATA;
                    end else begin
                        r_scl_oe <= 1'b1;
                    end
                    S_RD_DATA: if (w_fall) begin
                        r_bits   <= r_bits + 1'b1;
                        r_shift  <= {r_shift[WIDTH-2:0], 1'b0};
                        r_sda_oe <= (r_bits == 3'd7) ? 1'b0 : ~r_shift[WIDTH-1];
                        if (r_bits == 3'd7) r_state <= S_RD_ACK;
                    end
                    S_RD_ACK: if (w_rise) begin
                        r_nack_det <= w_sda;
                        r_phase    <= ~w_sda;
                        if (w_sda) r_state <= S_IGNORE;
                    end else if (w_fall && r_phase) begin
                        r_phase <= 1'b0;
                        r_state <= S_RD_LOAD;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_scl_oe   = r_scl_oe;
    assign o_sda_oe   = r_sda_oe;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;
    assign o_tx_ready = r_tx_ready;
    assign o_nack_det = r_nack_det;
    assign o_busy     = !(r_state inside {S_IDLE, S_ADDR, S_IGNORE});
endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: directed bus-controller scenarios against i2c_target
module tb_i2c_target;
    localparam int Q = 25;

    logic clk = 1'b0, rst_n = 1'b0;
    logic scl_c = 1'b1, sda_c = 1'b1;
    logic scl_pad, sda_pad;
    logic scl_oe, sda_oe, rx_valid, tx_ready, busy, nack_det;
    logic rx_ready = 1'b1, tx_valid = 1'b0;
    logic [7:0] rx_data, tx_data = 8'h00;
    int checks = 0, errors = 0;
    int rx_n = 0, tx_n = 0, nack_n = 0, oe_n = 0, busy_n = 0;
    logic [7:0] rx_log [16];

    assign scl_pad = scl_c & ~scl_oe;
    assign sda_pad = sda_c & ~sda_oe;

    i2c_target dut (
        .clk(clk), .rst_n(rst_n), .i_scl(scl_pad), .i_sda(sda_pad),
        .o_scl_oe(scl_oe), .o_sda_oe(sda_oe), .o_rx_data(rx_data), .o_rx_valid(rx_valid),
        .i_rx_ready(rx_ready), .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
        .o_busy(busy), .o_nack_det(nack_det)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) begin
            rx_log[rx_n[3:0]] <= rx_data;
            rx_n <= rx_n + 1;
        end
        if (tx_ready) tx_n <= tx_n + 1;
        if (nack_det) nack_n <= nack_n + 1;
        if (sda_oe) oe_n <= oe_n + 1;
        if (busy) busy_n <= busy_n + 1;
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_c = 1'b1; wait_q();
        scl_c = 1'b1; wait_q();
        sda_c = 1'b0; wait_q();
        scl_c = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_c = 1'b0; wait_q();
        scl_c = 1'b1; wait_q();
        sda_c = 1'b1; wait_q();
    endtask

    task automatic bus_bit(input logic b, input logic glitch, output logic r);
        int n;
        sda_c = b;
        wait_q();
        scl_c = 1'b1;
        n = 0;
        while (scl_pad !== 1'b1 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL scl_wait: SCL still low after %0d cycles, required released", n);
        end
        if (glitch) begin
            repeat (8) @(negedge clk);
            sda_c = 1'b0;
            repeat (2) @(negedge clk);
            sda_c = b;
        end
        wait_q();
        r = sda_pad;
        scl_c = 1'b0;
        wait_q();
    endtask

    task automatic bus_byte(input logic [7:0] d, output logic [7:0] r);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(d[i], 1'b0, b);
            r[i] = b;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({scl_oe, sda_oe, rx_valid, tx_ready, busy, nack_det, rx_data} !== 14'h0) begin
            errors++;
            $display("FAIL reset_hold: outputs %h, required 0", {scl_oe, sda_oe, rx_valid, tx_ready, busy, nack_det, rx_data});
        end
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if ({scl_oe, sda_oe, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle: scl_oe/sda_oe/busy %b, required 000", {scl_oe, sda_oe, busy});
        end
    endtask

    task automatic test_write();
        logic [7:0] d;
        logic a;
        int r0, r1;
        rx_ready = 1'b1;
        r0 = rx_n;
        bus_start();
        bus_byte(8'h84, d);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL wr_addr_ack: sda %b, required 0", a); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL wr_busy: busy %b, required 1", busy); end
        bus_byte(8'hA5, d);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL wr_data1_ack: sda %b, required 0", a); end
        bus_byte(8'h3C, d);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL wr_data2_ack: sda %b, required 0", a); end
        bus_stop();
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL wr_stop_busy: busy %b, required 0", busy); end
        checks++;
        if (rx_n - r0 != 2) begin errors++; $display("FAIL wr_rx_count: %0d strobes, required 2", rx_n - r0); end
        r1 = r0 + 1;
        checks++;
        if (rx_log[r0[3:0]] !== 8'hA5 || rx_log[r1[3:0]] !== 8'h3C) begin
            errors++;
            $display("FAIL wr_rx_data: got %h %h, required a5 3c", rx_log[r0[3:0]], rx_log[r1[3:0]]);
        end
    endtask

    task automatic test_read();
        logic [7:0] d1, d2, x;
        logic a;
        int t0, n0;
        t0 = tx_n;
        n0 = nack_n;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        bus_start();
        bus_byte(8'h85, x);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL rd_addr_ack: sda %b, required 0", a); end
        bus_byte(8'hFF, d1);
        tx_data = 8'hC3;
        bus_bit(1'b0, 1'b0, a);
        bus_byte(8'hFF, d2);
        bus_bit(1'b1, 1'b0, a);
        bus_stop();
        tx_valid = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (d1 !== 8'h5A || d2 !== 8'hC3) begin errors++; $display("FAIL rd_data: got %h %h, required 5a c3", d1, d2); end
        checks++;
        if (tx_n - t0 != 2) begin errors++; $display("FAIL rd_tx_ready: %0d strobes, required 2", tx_n - t0); end
        checks++;
        if (nack_n - n0 != 1) begin errors++; $display("FAIL rd_nack_det: %0d strobes, required 1", nack_n - n0); end
    endtask

    task automatic test_wrong_addr();
        logic [7:0] x;
        logic a;
        int o0, b0, s0;
        bus_start();
        o0 = oe_n;
        b0 = busy_n;
        s0 = rx_n + tx_n + nack_n;
        bus_byte(8'h90, x);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL wa_nack: sda %b, required 1", a); end
        bus_byte(8'h00, x);
        bus_bit(1'b1, 1'b0, a);
        bus_stop();
        repeat (10) @(negedge clk);
        checks++;
        if (oe_n != o0 || busy_n != b0) begin
            errors++;
            $display("FAIL wa_quiet: sda_oe cycles %0d busy cycles %0d, required 0 0", oe_n - o0, busy_n - b0);
        end
        checks++;
        if (rx_n + tx_n + nack_n != s0) begin errors++; $display("FAIL wa_strobes: %0d, required 0", rx_n + tx_n + nack_n - s0); end
    endtask

    task automatic test_stretch();
        logic [7:0] d, x;
        logic a, ak;
        int bad, n;
        tx_valid = 1'b0;
        bus_start();
        bus_byte(8'h85, x);
        bus_bit(1'b1, 1'b0, ak);
        checks++;
        if (ak !== 1'b0) begin errors++; $display("FAIL st_addr_ack: sda %b, required 0", ak); end
        fork
            begin
                bus_byte(8'hFF, d);
                bus_bit(1'b1, 1'b0, a);
            end
            begin
                n = 0;
                while (scl_oe !== 1'b1 && n < 200) begin @(negedge clk); n++; end
                bad = 0;
                repeat (200) begin
                    @(negedge clk);
                    if (scl_oe !== 1'b1) bad++;
                end
                checks++;
                if (bad != 0) begin errors++; $display("FAIL st_hold: scl_oe low %0d of 200 cycles, required 0", bad); end
                tx_data = 8'h6B;
                tx_valid = 1'b1;
                @(posedge clk);
                #1;
                checks++;
                if ({scl_oe, sda_oe, tx_ready} !== 3'b011) begin
                    errors++;
                    $display("FAIL st_release: scl_oe/sda_oe/tx_ready %b, required 011", {scl_oe, sda_oe, tx_ready});
                end
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        bus_stop();
        checks++;
        if (d !== 8'h6B) begin errors++; $display("FAIL st_data: got %h, required 6b", d); end
    endtask

    task automatic test_write_nack();
        logic [7:0] d, x;
        logic a;
        int r0;
        rx_ready = 1'b0;
        r0 = rx_n;
        bus_start();
        bus_byte(8'h84, x);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL wn_addr_ack: sda %b, required 0", a); end
        bus_byte(8'h11, x);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b1) begin errors++; $display("FAIL wn_data_nack: sda %b, required 1", a); end
        checks++;
        if (rx_n != r0) begin errors++; $display("FAIL wn_rx_valid: %0d strobes, required 0", rx_n - r0); end
        tx_data = 8'h77;
        tx_valid = 1'b1;
        bus_start();
        bus_byte(8'h85, x);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL wn_rs_ack: sda %b, required 0", a); end
        bus_byte(8'hFF, d);
        bus_bit(1'b1, 1'b0, a);
        bus_stop();
        tx_valid = 1'b0;
        rx_ready = 1'b1;
        checks++;
        if (d !== 8'h77) begin errors++; $display("FAIL wn_rs_data: got %h, required 77", d); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] x;
        logic a, b;
        int r0;
        bus_start();
        bus_byte(8'h84, x);
        checks++;
        if (sda_oe !== 1'b1) begin errors++; $display("FAIL rm_pre_ack: sda_oe %b, required 1", sda_oe); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sda_oe, scl_oe} !== 2'b00) begin errors++; $display("FAIL rm_async: sda_oe/scl_oe %b, required 00", {sda_oe, scl_oe}); end
        sda_c = 1'b1;
        scl_c = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_idle: busy %b, required 0", busy); end
        r0 = rx_n;
        bus_start();
        bus_byte(8'h84, x);
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL rm_addr_ack: sda %b, required 0", a); end
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, i == 4, b);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL rm_glitch_busy: busy %b, required 1", busy); end
        bus_bit(1'b1, 1'b0, a);
        checks++;
        if (a !== 1'b0) begin errors++; $display("FAIL rm_data_ack: sda %b, required 0", a); end
        bus_stop();
        repeat (10) @(negedge clk);
        checks++;
        if (rx_n - r0 != 1 || rx_log[r0[3:0]] !== 8'hFF) begin
            errors++;
            $display("FAIL rm_rx: %0d strobes data %h, required 1 ff", rx_n - r0, rx_log[r0[3:0]]);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_wrong_addr();
        test_stretch();
        test_write_nack();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
